// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_KILL
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: reset, word-aligned load of a redirect target, or step by one word.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] target_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_word(target_i);
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, output register to decode,
// branch/flush redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCsrc,
  input  logic [31:0] pc_target,
  input  logic        flush,
  input  logic        stall,
  fetch_if.master     imem,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  fetch_pc;
  logic         consume, redirect, req_valid, load_pc, inc_pc;

  assign consume  = valid_q & ~stall;
  assign redirect = flush | (PCsrc & consume);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_pc),
    .target_i (pc_target),
    .inc_i    (inc_pc),
    .pc_o     (fetch_pc)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    req_valid = 1'b0;
    load_pc   = 1'b0;
    inc_pc    = 1'b0;
    unique case (state_q)
      FS_REQ: begin
        req_valid = ~redirect & (~valid_q | consume);
        if (consume) valid_d = 1'b0;
        if (req_valid & imem.imem_req_ready) state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem.imem_rsp_valid & ~flush) begin
          instr_d = imem.imem_rsp_data;
          pc_d    = fetch_pc;
          valid_d = 1'b1;
          inc_pc  = 1'b1;
          state_d = FS_REQ;
        end else if (flush) begin
          // A response arriving with the flush is dropped here; otherwise it is still in flight.
          state_d = imem.imem_rsp_valid ? FS_REQ : FS_KILL;
        end
      end
      FS_KILL: begin
        if (imem.imem_rsp_valid) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
    if (redirect) begin
      load_pc = 1'b1;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FS_REQ;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = fetch_pc;
  assign instr               = instr_q;
  assign pc                  = pc_q;
  assign pc_plus4            = pc_q + PC_STEP;
  assign instr_valid         = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small latency-configurable imem model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n, rst2_n;
  logic        PCsrc, flush, stall;
  logic [31:0] pc_target;
  logic        PCsrc2, flush2, stall2;
  logic [31:0] pc_target2;
  logic [31:0] instr1, pc1, pp1;
  logic        v1;
  logic [31:0] instr2, pc2, pp2;
  logic        v2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned lat     = 1;
  int unsigned cnt     = 0;
  int unsigned rsp_count = 0;
  int unsigned rsp_base  = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  fetch_if m1 ();
  fetch_if m2 ();

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCsrc       (PCsrc),
    .pc_target   (pc_target),
    .flush       (flush),
    .stall       (stall),
    .imem        (m1.master),
    .instr       (instr1),
    .pc          (pc1),
    .pc_plus4    (pp1),
    .instr_valid (v1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst_n       (rst2_n),
    .PCsrc       (PCsrc2),
    .pc_target   (pc_target2),
    .flush       (flush2),
    .stall       (stall2),
    .imem        (m2.master),
    .instr       (instr2),
    .pc          (pc2),
    .pc_plus4    (pp2),
    .instr_valid (v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + a;
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // imem model for dut: handshake seen in cycle N answers in cycle N+lat
  initial begin
    m1.imem_rsp_valid = 1'b0;
    m1.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      m1.imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            m1.imem_rsp_valid = 1'b1;
            m1.imem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
            rsp_count++;
          end
        end
        if (m1.imem_req_valid && m1.imem_req_ready) begin
          pend      = 1'b1;
          cnt       = lat;
          pend_addr = m1.imem_addr;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; PCsrc = 1'b0; flush = 1'b0; stall = 1'b0; pc_target = '0;
    m1.imem_req_ready = 1'b1;
    rst2_n = 1'b0; PCsrc2 = 1'b0; flush2 = 1'b0; stall2 = 1'b0; pc_target2 = '0;
    m2.imem_req_ready = 1'b1; m2.imem_rsp_valid = 1'b0; m2.imem_rsp_data = '0;

    @(negedge clk); #1;
    check32("rst_instr", instr1, 32'h0000_0013);
    check32("rst_valid", 32'(v1), 32'd0);
    check32("rst_pc", pc1, 32'h0);

    @(negedge clk); rst_n = 1'b1; #1;
    check32("c1_req", 32'(m1.imem_req_valid), 32'd1);
    check32("c1_addr", m1.imem_addr, 32'h0);

    @(negedge clk); #1;
    check32("wait_noreq", 32'(m1.imem_req_valid), 32'd0);

    @(negedge clk); stall = 1'b1; #1;
    check32("c3_instr", instr1, 32'h0050_0093);
    check32("c3_pc", pc1, 32'h0);
    check32("c3_pc4", pp1, 32'h4);
    check32("c3_valid", 32'(v1), 32'd1);
    check32("stall_noreq", 32'(m1.imem_req_valid), 32'd0);
    repeat (2) begin
      @(negedge clk); #1;
      check32("stall_instr", instr1, 32'h0050_0093);
      check32("stall_valid", 32'(v1), 32'd1);
      check32("stall_req", 32'(m1.imem_req_valid), 32'd0);
    end

    @(negedge clk); stall = 1'b0; #1;
    check32("unstall_req", 32'(m1.imem_req_valid), 32'd1);
    check32("unstall_addr", m1.imem_addr, 32'h4);

    @(negedge clk); #1;
    check32("consumed_valid", 32'(v1), 32'd0);

    @(negedge clk); #1;
    check32("i4_instr", instr1, mem_word(32'h4));
    check32("i4_pc", pc1, 32'h4);
    check32("i4_req_addr", m1.imem_addr, 32'h8);

    @(negedge clk); #1;
    @(negedge clk); PCsrc = 1'b1; pc_target = 32'h20; #1;
    check32("br_pc", pc1, 32'h8);
    check32("br_valid", 32'(v1), 32'd1);
    check32("br_noreq", 32'(m1.imem_req_valid), 32'd0);

    @(negedge clk); PCsrc = 1'b0; #1;
    check32("br_kill_valid", 32'(v1), 32'd0);
    check32("br_kill_instr", instr1, 32'h0000_0013);
    check32("br_req", 32'(m1.imem_req_valid), 32'd1);
    check32("br_addr", m1.imem_addr, 32'h20);

    @(negedge clk); #1;
    @(negedge clk); lat = 3; #1;
    check32("tgt_pc", pc1, 32'h20);
    check32("tgt_instr", instr1, mem_word(32'h20));
    check32("tgt_next_addr", m1.imem_addr, 32'h24);

    @(negedge clk); flush = 1'b1; pc_target = 32'h102; #1;
    check32("fl_noreq", 32'(m1.imem_req_valid), 32'd0);
    @(negedge clk); flush = 1'b0; #1;
    check32("kill_noreq", 32'(m1.imem_req_valid), 32'd0);
    check32("kill_addr", m1.imem_addr, 32'h100);
    @(negedge clk); #1;
    check32("kill_noreq2", 32'(m1.imem_req_valid), 32'd0);

    @(negedge clk); lat = 1; m1.imem_req_ready = 1'b0; rsp_base = rsp_count; #1;
    check32("stale_dropped", 32'(v1), 32'd0);
    repeat (4) begin
      check32("nrdy_req", 32'(m1.imem_req_valid), 32'd1);
      check32("nrdy_addr", m1.imem_addr, 32'h100);
      @(negedge clk); #1;
    end
    m1.imem_req_ready = 1'b1;
    check32("rdy_req", 32'(m1.imem_req_valid), 32'd1);
    check32("rdy_addr", m1.imem_addr, 32'h100);
    @(negedge clk); #1;
    @(negedge clk); stall = 1'b1; #1;
    check32("fl_pc", pc1, 32'h100);
    check32("fl_instr", instr1, mem_word(32'h100));
    check32("fl_valid", 32'(v1), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check32("one_rsp", rsp_count - rsp_base, 32'd1);

    // wrap-around instance
    @(negedge clk); rst2_n = 1'b1; #1;
    check32("w_addr", m2.imem_addr, 32'hFFFF_FFFC);
    check32("w_req", 32'(m2.imem_req_valid), 32'd1);
    @(negedge clk); m2.imem_rsp_valid = 1'b1; m2.imem_rsp_data = 32'hDEAD_BEEF; #1;
    check32("w_wait_noreq", 32'(m2.imem_req_valid), 32'd0);
    @(negedge clk); m2.imem_rsp_valid = 1'b0; stall2 = 1'b1; #1;
    check32("w_instr", instr2, 32'hDEAD_BEEF);
    check32("w_pc", pc2, 32'hFFFF_FFFC);
    check32("w_pc4", pp2, 32'h0);
    check32("w_valid", 32'(v2), 32'd1);
    check32("w_fetch_wrap", m2.imem_addr, 32'h0);
    @(negedge clk); stall2 = 1'b0; #1;
    check32("w_req0", 32'(m2.imem_req_valid), 32'd1);
    @(negedge clk); rst2_n = 1'b0; #1;
    check32("w_in_wait", 32'(m2.imem_req_valid), 32'd0);
    @(negedge clk); #1;
    check32("wr_instr", instr2, 32'h0000_0013);
    check32("wr_pc", pc2, 32'hFFFF_FFFC);
    check32("wr_valid", 32'(v2), 32'd0);
    check32("wr_addr", m2.imem_addr, 32'hFFFF_FFFC);
    rst2_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the control/decode unit. It holds the PC, issues single-outstanding word requests to instruction memory over a valid/ready handshake, and captures each returned word into an output register. That register presents `instr`, `pc` and `pc_plus4` to decode. It also applies the branch redirect (`PCsrc`, `pc_target`) produced by control and the ALU, plus an external `flush`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `PCsrc`  in  1  branch taken, from control; only meaningful while `instr_valid`=1.
- `pc_target`  in  32  redirect target (branch target or flush vector).
- `flush`  in  1  unconditional redirect to `pc_target`.
- `stall`  in  1  downstream is not consuming this cycle.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  word address of the request (= `fetch_pc`).
- `imem_rsp_valid`  in  1  response data valid; 1-cycle pulse, no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `instr`  out  32  registered instruction to decode.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc`+4, combinational from `pc`.
- `instr_valid`  out  1  `instr`/`pc` hold a live instruction.

## Operation
- Internal signals:
  - `fetch_pc` (32 bits): next address to fetch.
  - Output register: `instr`, `pc`, `instr_valid`.
  - FSM states: REQ, WAIT, KILL.
- consume = `instr_valid` & ~`stall`.
- redirect = `flush` | (`PCsrc` & `instr_valid` & ~`stall`).
- Redirect actions:
  - `fetch_pc` <= {`pc_target`[31:2], 2'b00}.
  - `instr_valid` <= 0.
  - `instr` <= NOP.
- REQ state:
  - `imem_req_valid` = ~redirect & (~`instr_valid` | consume).
  - Handshake (valid & ready): go to WAIT.
  - consume without a handshake: `instr_valid` <= 0; stay in REQ.
- WAIT state (`instr_valid` is always 0 here):
  - `imem_rsp_valid` & ~`flush`: `instr` <= `imem_rsp_data`, `pc` <= `fetch_pc`, `instr_valid` <= 1, `fetch_pc` <= `fetch_pc`+4; go to REQ.
  - `flush` without a response: redirect; go to KILL.
  - `flush` and response in the same cycle: drop the response; redirect; go to REQ.
- KILL state:
  - Wait for the stale response and discard it; go to REQ.
  - A further `flush` in KILL updates `fetch_pc` again; stay in KILL (or go to REQ if the response arrives in that cycle).
- Single outstanding request. A response only ever lands in an empty output register, so no skid buffer is needed.
- `imem_rsp_valid` in REQ is a protocol error: ignore it.
- All PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- A `PCsrc` with `instr_valid`=0 or with `stall`=1 is ignored.

## Timing
- Reset values (synchronous, takes effect at the edge where `rst_n`=0):
  - state = REQ.
  - `fetch_pc` = `RESET_PC`.
  - `pc` = `RESET_PC`.
  - `instr` = 32'h0000_0013 (NOP, addi x0,x0,0).
  - `instr_valid` = 0.
  - `imem_req_valid` = 1 in the first cycle after reset release.
- Reset mid-WAIT/KILL aborts the request. Instruction memory shares `rst_n`, so no stale response follows.
- Latency: request handshake in cycle N, response in cycle N+k (k ≥ 1), `instr_valid`=1 from cycle N+k+1.
- Throughput, 1-cycle memory, no stalls: one instruction every 2 cycles. The next request issues in the same cycle the current instruction is consumed.
- Redirect via `PCsrc`: no request in that cycle. The request to `pc_target` issues in the next cycle.
- `imem_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0, unless a `flush` occurs.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum {FS_REQ, FS_WAIT, FS_KILL}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `PC_STEP` = 32'd4.
- One natural sub-module: `pc_reg`. It holds `fetch_pc` with reset, load-target and increment controls, and the 2-bit alignment clear.
- The FSM and output register stay in `fetch_stage`.

## Test plan
- Reset release, memory with ready=1 and 1-cycle latency returning 32'h0050_0093 → `imem_addr`=0 in cycle 1; `instr`=32'h0050_0093, `pc`=0, `pc_plus4`=4, `instr_valid`=1 in cycle 3.
- `stall` held 3 cycles while `instr_valid`=1 → `imem_req_valid`=0 and outputs frozen. After `stall` drops, the next request has `imem_addr`=4.
- `PCsrc`=1 with `pc_target`=32'h0000_0020 at `pc`=8 → `instr_valid`=0 next cycle, then a request at 32'h20, then `pc`=32'h20.
- `flush` with `pc_target`=32'h100 during WAIT, memory latency 3 → the stale response is discarded (`instr_valid` stays 0), the next request has `imem_addr`=32'h100.
- `imem_req_ready`=0 for 4 cycles → `imem_req_valid` and `imem_addr` held constant; exactly one response is captured.
- `RESET_PC`=32'hFFFF_FFFC → after capture, `fetch_pc` wraps to 0. Asserting `rst_n`=0 in WAIT → all outputs return to their reset values on the next edge.
